// File: rtl/fifo_ctrl_pkg.sv
// Shared constants and types for the FIFO pointer/flag controller.
// Sizes, FSM state codes and power-up threshold values live here so the
// controller, its interface and the bench agree on a single definition.
package fifo_ctrl_pkg;

  localparam int FIFO_DATA_WIDTH = 10;
  localparam int FIFO_ADDR_WIDTH = 3;
  localparam int FIFO_DEPTH      = 2 ** FIFO_ADDR_WIDTH;

  // FSM state codes, kept as plain constants so the debug port value is stable
  localparam logic [2:0] ST_RESET  = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_IDLE   = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;

  // Threshold values used until INIT loads real ones
  localparam logic [FIFO_ADDR_WIDTH:0] TH_AF_DEFAULT = (FIFO_ADDR_WIDTH + 1)'(7);
  localparam logic [FIFO_ADDR_WIDTH:0] TH_AE_DEFAULT = (FIFO_ADDR_WIDTH + 1)'(1);

  // Occupancy-derived status flags, decoded together
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  // Pointer advance; wraps modulo the depth through natural overflow
  function automatic logic [FIFO_ADDR_WIDTH-1:0] ptr_next(
    input logic [FIFO_ADDR_WIDTH-1:0] ptr
  );
    return ptr + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// Request and memory-side bundle between a FIFO client, the pointer
// controller and the 8x10 dual-pointer memory. The master modport is the
// client side; the slave modport is the controller.
interface fifo_ctrl_if
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
);

  // Client requests and configuration
  logic                  init;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_in;
  logic [ADDR_WIDTH:0]   th_almost_full;
  logic [ADDR_WIDTH:0]   th_almost_empty;

  // Memory controls
  logic                  wr_enb;
  logic                  rd_enb;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [DATA_WIDTH-1:0] mem_data_in;

  // Status and debug
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  error;
  logic [2:0]            state;

  modport master (
    output init, push, pop, data_in, th_almost_full, th_almost_empty,
    input  wr_enb, rd_enb, wr_ptr, rd_ptr, mem_data_in,
    input  count, full, empty, almost_full, almost_empty, error, state
  );

  modport slave (
    input  init, push, pop, data_in, th_almost_full, th_almost_empty,
    output wr_enb, rd_enb, wr_ptr, rd_ptr, mem_data_in,
    output count, full, empty, almost_full, almost_empty, error, state
  );

endinterface

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for an 8-deep, 10-bit dual-pointer memory.
// Converts push/pop requests into memory enables and addresses, tracks the
// occupancy, and decodes full/empty/almost flags from registered state.
// A small FSM gates all traffic: nothing moves until thresholds have been
// loaded in INIT, and any overflow/underflow freezes the block in ERROR
// until the next reset.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  fifo_ctrl_if.slave  bus
);

  localparam int AW = FIFO_ADDR_WIDTH;
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  logic [2:0]    state_q,  state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic [AW:0]   th_af_q,  th_af_d;
  logic [AW:0]   th_ae_q,  th_ae_d;
  logic          error_q,  error_d;

  logic        traffic_ok;
  logic        wr_enb;
  logic        rd_enb;
  logic        overflow;
  logic        underflow;
  fifo_flags_t flags;

  // Status flags depend only on registered occupancy and thresholds, so a
  // request never ripples combinationally into full/empty.
  always_comb begin
    flags              = '0;
    flags.full         = (count_q == DEPTH_CNT);
    flags.empty        = (count_q == '0);
    flags.almost_full  = (count_q >= th_af_q);
    flags.almost_empty = (count_q <= th_ae_q);
  end

  // Request qualification. A pop frees a slot in the same edge, so a push at
  // full is accepted when paired with a pop; a pop at empty is never accepted,
  // which means push+pop at empty only writes.
  always_comb begin
    traffic_ok = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
    wr_enb     = traffic_ok & bus.push & (~flags.full | bus.pop);
    rd_enb     = traffic_ok & bus.pop & ~flags.empty;
    overflow   = traffic_ok & bus.push & flags.full & ~bus.pop;
    underflow  = traffic_ok & bus.pop & flags.empty;
  end

  // Next pointers, occupancy, thresholds and sticky error
  always_comb begin
    wr_ptr_d = wr_enb ? ptr_next(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_enb ? ptr_next(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + {{AW{1'b0}}, wr_enb} - {{AW{1'b0}}, rd_enb};
    th_af_d  = th_af_q;
    th_ae_d  = th_ae_q;
    if (state_q == ST_INIT) begin
      th_af_d = bus.th_almost_full;
      th_ae_d = bus.th_almost_empty;
    end
    error_d  = error_q | overflow | underflow;
  end

  // FSM next state: INIT holds while init is high, IDLE waits for the first
  // accepted write, ACTIVE drops back to IDLE once the FIFO drains, and any
  // rejected request lands in ERROR, which only reset leaves.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT: begin
        if (!bus.init) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.init)       state_d = ST_INIT;
        else if (underflow) state_d = ST_ERROR;
        else if (wr_enb)    state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (overflow || underflow) state_d = ST_ERROR;
        else if (count_d == '0)    state_d = ST_IDLE;
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase
  end

  // State register; reset returns every output to its quiescent value at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RESET;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      th_af_q  <= TH_AF_DEFAULT;
      th_ae_q  <= TH_AE_DEFAULT;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      th_af_q  <= th_af_d;
      th_ae_q  <= th_ae_d;
      error_q  <= error_d;
    end
  end

  assign bus.wr_enb       = wr_enb;
  assign bus.rd_enb       = rd_enb;
  assign bus.wr_ptr       = wr_ptr_q;
  assign bus.rd_ptr       = rd_ptr_q;
  assign bus.mem_data_in  = bus.data_in;
  assign bus.count        = count_q;
  assign bus.full         = flags.full;
  assign bus.empty        = flags.empty;
  assign bus.almost_full  = flags.almost_full;
  assign bus.almost_empty = flags.almost_empty;
  assign bus.error        = error_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl. A stimulus process drives one request
// per cycle and queues the expected cycle response from a queue-level
// reference model; a monitor process pops and compares each response and
// checks read data against the order of accepted writes.
module tb_fifo_ctrl;
  import fifo_ctrl_pkg::*;

  typedef struct {
    int state;
    int count;
    int wr_ptr;
    int rd_ptr;
    int wr_enb;
    int rd_enb;
    int full;
    int empty;
    int af;
    int ae;
    int error;
    int data;
  } exp_t;

  logic clk;
  logic rst_n;

  fifo_ctrl_if bus ();

  fifo_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  exp_t        expQ[$];
  int          sbData[$];
  logic [9:0]  memModel [FIFO_DEPTH];

  // Reference model: mode, occupancy, total accepted writes/reads
  int mMode;
  int mOcc;
  int mWrTot;
  int mRdTot;
  int mThAf;
  int mThAe;
  int mErr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one request at a negedge, queue the expected response, advance the model
  task automatic applyStimulus(input bit pu, input bit po, input bit initV, input int d);
    exp_t e;
    bit   pass, accW, accR, bad;
    int   newOcc;
    bus.push    = pu;
    bus.pop     = po;
    bus.init    = initV;
    bus.data_in = 10'(d);

    pass = (mMode == int'(ST_IDLE)) || (mMode == int'(ST_ACTIVE));
    accW = pass && pu && ((mOcc < FIFO_DEPTH) || po);
    accR = pass && po && (mOcc > 0);
    bad  = pass && ((pu && mOcc == FIFO_DEPTH && !po) || (po && mOcc == 0));

    e.state  = mMode;
    e.count  = mOcc;
    e.wr_ptr = mWrTot % FIFO_DEPTH;
    e.rd_ptr = mRdTot % FIFO_DEPTH;
    e.wr_enb = int'(accW);
    e.rd_enb = int'(accR);
    e.full   = int'(mOcc == FIFO_DEPTH);
    e.empty  = int'(mOcc == 0);
    e.af     = int'(mOcc >= mThAf);
    e.ae     = int'(mOcc <= mThAe);
    e.error  = mErr;
    e.data   = d & 10'h3FF;
    expQ.push_back(e);
    if (accW) sbData.push_back(d & 10'h3FF);

    newOcc = mOcc + int'(accW) - int'(accR);
    if (mMode == int'(ST_RESET)) mMode = int'(ST_INIT);
    else if (mMode == int'(ST_INIT)) begin
      mThAf = int'(bus.th_almost_full);
      mThAe = int'(bus.th_almost_empty);
      if (!initV) mMode = int'(ST_IDLE);
    end else if (mMode == int'(ST_IDLE)) begin
      if (initV) mMode = int'(ST_INIT);
      else if (po && mOcc == 0) mMode = int'(ST_ERROR);
      else if (accW) mMode = int'(ST_ACTIVE);
    end else if (mMode == int'(ST_ACTIVE)) begin
      if (bad) mMode = int'(ST_ERROR);
      else if (newOcc == 0) mMode = int'(ST_IDLE);
    end
    if (bad) mErr = 1;
    mOcc   = newOcc;
    mWrTot += int'(accW);
    mRdTot += int'(accR);
    @(negedge clk);
  endtask

  // Assert reset mid-cycle, check the immediate reset values, release at a negedge
  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_state",  int'(bus.state), int'(ST_RESET));
    checkOutput("rst_wr_ptr", int'(bus.wr_ptr), 0);
    checkOutput("rst_rd_ptr", int'(bus.rd_ptr), 0);
    checkOutput("rst_count",  int'(bus.count), 0);
    checkOutput("rst_wr_enb", int'(bus.wr_enb), 0);
    checkOutput("rst_rd_enb", int'(bus.rd_enb), 0);
    checkOutput("rst_empty",  int'(bus.empty), 1);
    checkOutput("rst_ae",     int'(bus.almost_empty), 1);
    checkOutput("rst_full",   int'(bus.full), 0);
    checkOutput("rst_af",     int'(bus.almost_full), 0);
    checkOutput("rst_error",  int'(bus.error), 0);
    mMode = int'(ST_RESET); mOcc = 0; mWrTot = 0; mRdTot = 0;
    mThAf = 7; mThAe = 1; mErr = 0;
    sbData.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare each queued response, then track memory traffic
  initial begin
    exp_t e;
    int   rdExp;
    forever begin
      @(negedge clk);
      #2;
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("state",  int'(bus.state), e.state);
        checkOutput("count",  int'(bus.count), e.count);
        checkOutput("wr_ptr", int'(bus.wr_ptr), e.wr_ptr);
        checkOutput("rd_ptr", int'(bus.rd_ptr), e.rd_ptr);
        checkOutput("wr_enb", int'(bus.wr_enb), e.wr_enb);
        checkOutput("rd_enb", int'(bus.rd_enb), e.rd_enb);
        checkOutput("full",   int'(bus.full), e.full);
        checkOutput("empty",  int'(bus.empty), e.empty);
        checkOutput("almost_full",  int'(bus.almost_full), e.af);
        checkOutput("almost_empty", int'(bus.almost_empty), e.ae);
        checkOutput("error",  int'(bus.error), e.error);
        checkOutput("mem_data_in", int'(bus.mem_data_in), e.data);
        if (bus.rd_enb) begin
          if (sbData.size() == 0) begin
            checkOutput("rd_unexpected", 1, 0);
          end else begin
            rdExp = sbData.pop_front();
            checkOutput("rd_data", int'(memModel[bus.rd_ptr]), rdExp);
          end
        end
        if (bus.wr_enb) memModel[bus.wr_ptr] = bus.mem_data_in;
      end
    end
  end

  initial begin
    bit pu, po, iv;
    int pushPct, popPct;
    rst_n = 1'b1;
    bus.init = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.data_in = '0;
    bus.th_almost_full = 4'd6; bus.th_almost_empty = 4'd2;
    #2;

    // Bring-up with thresholds 6/2, fill, drain
    doReset();
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 25 + 20 * i);
    applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // Simultaneous push+pop at full and at empty
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 300 + i);
    applyStimulus(1, 1, 0, 200);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 1, 0, 411);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // Overflow into ERROR, traffic blocked, reset mid-ERROR
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 500 + i);
    applyStimulus(1, 0, 0, 777);
    applyStimulus(1, 1, 0, 778);
    applyStimulus(0, 1, 0, 0);
    doReset();

    // Underflow from IDLE
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // Randomized segments with random thresholds and traffic mix
    for (int seg = 0; seg < 10; seg++) begin
      doReset();
      bus.th_almost_full  = 4'($urandom_range(0, 8));
      bus.th_almost_empty = 4'($urandom_range(0, 8));
      pushPct = 30 + 20 * int'($urandom_range(0, 2));
      popPct  = 100 - pushPct;
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) applyStimulus(0, 0, 1, 0);
      for (int k = 0; k < 150; k++) begin
        iv = ($urandom_range(0, 99) < 2);
        pu = ($urandom_range(0, 99) < pushPct);
        po = ($urandom_range(0, 99) < popPct);
        if ($urandom_range(0, 99) >= 4) begin
          if (pu && mOcc == FIFO_DEPTH && !po) pu = 0;
          if (po && mOcc == 0) po = 0;
        end
        applyStimulus(pu, po, iv, int'($urandom_range(0, 1023)));
      end
    end

    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
